// File: rtl/ahb_common_pkg.sv
// Shared AHB encodings used by bus-facing blocks.
package ahb_common_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'd0,
        RESP_ERROR = 2'd1,
        RESP_RETRY = 2'd2,
        RESP_SPLIT = 2'd3
    } hresp_e;

endpackage : ahb_common_pkg

// File: rtl/ahb_cmd_manager.sv
// AHB manager: turns a valid/ready command stream into single NONSEQ
// transfers. An address-phase slot (A) and a data-phase slot (D) form
// the bus pipeline. A two-cycle error response drops the bus to IDLE
// and then reissues whatever was waiting in A.
module ahb_cmd_manager
    import ahb_common_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 nReset,
    // command side
    input  logic                 cmdValid,
    output logic                 cmdReady,
    input  logic [AddrWidth-1:0] cmdAddr,
    input  logic [DataWidth-1:0] cmdWData,
    input  logic                 cmdWrite,
    input  logic [2:0]           cmdSize,
    // completion side
    output logic                 rspValid,
    output logic [DataWidth-1:0] rspData,
    output logic                 rspErr,
    // AHB manager side
    output logic [AddrWidth-1:0] addr,
    output logic [1:0]           trans,
    output logic                 write,
    output logic [3:0]           control,
    output logic [DataWidth-1:0] wData,
    input  logic [DataWidth-1:0] rData,
    input  logic [1:0]           resp,
    input  logic                 readyOut
);

    typedef struct packed {
        logic                 valid;
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] wdata;
        logic                 write;
        logic [2:0]           size;
    } slot_a_t;

    slot_a_t              a_q, a_d;
    logic                 d_valid_q, d_valid_d;
    logic                 d_write_q, d_write_d;
    logic [DataWidth-1:0] d_wdata_q, d_wdata_d;
    logic                 err_hold_q, err_hold_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;

    logic accept;
    logic err_first;

    // First cycle of a two-cycle error response on the transfer in D.
    assign err_first = d_valid_q && !readyOut && (resp != RESP_OKAY);

    assign cmdReady = nReset && readyOut && !err_hold_q;
    assign accept   = cmdValid && cmdReady;

    // Address phase comes from A; it is withheld during both error cycles
    // so the waiting command is not taken by the subordinate.
    assign addr    = a_q.addr;
    assign write   = a_q.write;
    assign control = {1'b0, a_q.size};
    assign trans   = (a_q.valid && !err_hold_q && !err_first) ? TRANS_NONSEQ : TRANS_IDLE;
    assign wData   = d_wdata_q;

    assign rspValid = rsp_valid_q;
    assign rspData  = rsp_data_q;
    assign rspErr   = rsp_err_q;

    // Next-state for the pipeline slots, the error hold and the completion pulse.
    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        a_d         = a_q;
        d_valid_d   = d_valid_q;
        d_write_d   = d_write_q;
        d_wdata_d   = d_wdata_q;
        err_hold_d  = err_hold_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;

        if (err_first) begin
            err_hold_d = 1'b1;
        end

        if (readyOut) begin
            err_hold_d = 1'b0;

            if (d_valid_q) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_hold_q || (resp != RESP_OKAY);
                rsp_data_d  = d_write_q ? '0 : rData;
            end

            if (err_hold_q) begin
                // Second error cycle: D retires, A stays for reissue.
                d_valid_d = 1'b0;
            end else begin
                d_valid_d = a_q.valid;
                if (a_q.valid) begin
                    d_write_d = a_q.write;
                    d_wdata_d = a_q.wdata;
                end
                a_d.valid = accept;
                if (accept) begin
                    a_d.addr  = cmdAddr;
                    a_d.wdata = cmdWData;
                    a_d.write = cmdWrite;
                    a_d.size  = cmdSize;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            // NOTE: payload fields are reset too, so the bus reads all-zero in reset.
            a_q         <= '0;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            d_wdata_q   <= '0;
            err_hold_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            a_q         <= a_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            d_wdata_q   <= d_wdata_d;
            err_hold_q  <= err_hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule : ahb_cmd_manager

// File: tb/tb_ahb_cmd_manager.sv
// Bench for ahb_cmd_manager: a command stimulus queue, a subordinate model
// with a per-transfer plan (wait states, error) and a memory, and an
// in-order scoreboard for address phases and completions.
module tb_ahb_cmd_manager;
    import ahb_common_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          nReset;
    logic          cmdValid, cmdReady, cmdWrite;
    logic [AW-1:0] cmdAddr;
    logic [DW-1:0] cmdWData;
    logic [2:0]    cmdSize;
    logic          rspValid, rspErr;
    logic [DW-1:0] rspData;
    logic [AW-1:0] addr;
    logic [1:0]    trans;
    logic          write;
    logic [3:0]    control;
    logic [DW-1:0] wData, rData;
    logic [1:0]    resp;
    logic          readyOut;

    ahb_cmd_manager #(.AddrWidth(AW), .DataWidth(DW)) dut (
        .clk(clk), .nReset(nReset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdAddr(cmdAddr),
        .cmdWData(cmdWData), .cmdWrite(cmdWrite), .cmdSize(cmdSize),
        .rspValid(rspValid), .rspData(rspData), .rspErr(rspErr),
        .addr(addr), .trans(trans), .write(write), .control(control),
        .wData(wData), .rData(rData), .resp(resp), .readyOut(readyOut)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] wdata; logic write; logic [2:0] size; } cmd_t;
    typedef struct { int waits; bit err; } plan_t;
    typedef struct { int cycle; int lat; logic [DW-1:0] data; logic err; } rsp_t;

    int checks = 0;
    int errors = 0;
    int cycles = 0;

    cmd_t  stim_q[$];     // commands still to be offered
    cmd_t  acc_q[$];      // accepted, not yet seen as an address phase
    int    acc_cyc_q[$];  // accept cycle of each outstanding command
    plan_t plan_q[$];     // directed subordinate plans, in bus order
    rsp_t  rsp_log[$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    int  cmd_rate   = 100;
    bit  rand_plans = 0;

    // subordinate data-phase state
    bit            dp_active = 0;
    cmd_t          dp_cmd;
    int            dp_cycle, dp_waits;
    bit            dp_err;
    logic [DW-1:0] dp_rdata;

    bit            rsp_pending = 0;
    logic [DW-1:0] rsp_exp_data;
    logic          rsp_exp_err;

    bit            prev_wait = 0;
    logic [1:0]    prev_trans;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic w, input logic [2:0] s);
        cmd_t c;
        c.addr = a; c.wdata = d; c.write = w; c.size = s;
        return c;
    endfunction

    function automatic plan_t mkp(input int w, input bit e);
        plan_t p;
        p.waits = w; p.err = e;
        return p;
    endfunction

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return ~a;
    endfunction

    task automatic drive_slave();
        resp     = RESP_OKAY;
        readyOut = 1'b1;
        rData    = $urandom;
        if (dp_active) begin
            if (dp_cycle < dp_waits) begin
                readyOut = 1'b0;
            end else if (dp_err && dp_cycle == dp_waits) begin
                readyOut = 1'b0;
                resp     = RESP_ERROR;
            end else begin
                resp  = dp_err ? RESP_ERROR : RESP_OKAY;
                rData = dp_rdata;
            end
        end
    endtask

    task automatic drive_cmd();
        if (!cmdValid && stim_q.size() > 0 && $urandom_range(0, 99) < cmd_rate) begin
            cmdValid = 1'b1;
            cmdAddr  = stim_q[0].addr;
            cmdWData = stim_q[0].wdata;
            cmdWrite = stim_q[0].write;
            cmdSize  = stim_q[0].size;
        end
    endtask

    // One clock: observe at the falling edge, then update the model and
    // drive new inputs just after the rising edge.
    task automatic step();
        cmd_t  c;
        plan_t p;
        bit    done, sampled, accepted;
        @(negedge clk);
        cycles++;

        if (rsp_pending) begin
            check("rspValid", rspValid, 1'b1);
            check("rspData", rspData, rsp_exp_data);
            check("rspErr", rspErr, rsp_exp_err);
        end else begin
            check("rspValid_idle", rspValid, 1'b0);
        end
        rsp_pending = 0;
        if (rspValid) begin
            rsp_t r;
            r.cycle = cycles; r.data = rspData; r.err = rspErr;
            r.lat   = (acc_cyc_q.size() > 0) ? cycles - acc_cyc_q.pop_front() : -1;
            rsp_log.push_back(r);
        end

        check("cmdReady", cmdReady, readyOut && (resp == RESP_OKAY));
        if (resp == RESP_ERROR) check("trans_idle_in_error", trans, TRANS_IDLE);
        if (prev_wait && resp == RESP_OKAY) begin
            check("hold_trans", trans, prev_trans);
            check("hold_addr", addr, prev_addr);
            check("hold_wData", wData, prev_wdata);
        end

        done = dp_active && readyOut;
        if (done) begin
            if (dp_cmd.write) check("wData", wData, dp_cmd.wdata);
            rsp_pending  = 1;
            rsp_exp_err  = dp_err;
            rsp_exp_data = dp_cmd.write ? '0 : dp_rdata;
            if (dp_cmd.write && !dp_err) mem[dp_cmd.addr] = dp_cmd.wdata;
        end

        sampled = readyOut && (trans == TRANS_NONSEQ);
        if (sampled) begin
            if (acc_q.size() == 0) begin
                check("spurious_nonseq", trans, TRANS_IDLE);
                sampled = 0;
            end else begin
                c = acc_q.pop_front();
                check("addr", addr, c.addr);
                check("write", write, c.write);
                check("control", control, {1'b0, c.size});
            end
        end

        accepted = cmdValid && cmdReady;
        if (accepted) begin
            acc_q.push_back(stim_q.pop_front());
            acc_cyc_q.push_back(cycles);
        end

        prev_wait  = !readyOut && (resp == RESP_OKAY);
        prev_trans = trans;
        prev_addr  = addr;
        prev_wdata = wData;

        @(posedge clk);
        #1;
        if (done) dp_active = 0;
        else if (dp_active) dp_cycle++;
        if (sampled) begin
            if (plan_q.size() > 0) p = plan_q.pop_front();
            else if (rand_plans) p = mkp(($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 3)),
                                         $urandom_range(0, 99) < 15);
            else p = mkp(0, 0);
            dp_active = 1;
            dp_cmd    = c;
            dp_cycle  = 0;
            dp_waits  = p.waits;
            dp_err    = p.err;
            dp_rdata  = mem_read(c.addr);
        end
        if (accepted) cmdValid = 1'b0;
        drive_slave();
        drive_cmd();
    endtask

    task automatic drain(input string tag, input int bound);
        int n = 0;
        while ((stim_q.size() > 0 || acc_q.size() > 0 || dp_active || rsp_pending || cmdValid)
               && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) check({tag, "_timeout"}, n, 0);
        step();
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_trans"}, trans, TRANS_IDLE);
        check({tag, "_addr"}, addr, '0);
        check({tag, "_wData"}, wData, '0);
        check({tag, "_write"}, write, 1'b0);
        check({tag, "_control"}, control, 4'd0);
        check({tag, "_cmdReady"}, cmdReady, 1'b0);
        check({tag, "_rspValid"}, rspValid, 1'b0);
        check({tag, "_rspData"}, rspData, '0);
        check({tag, "_rspErr"}, rspErr, 1'b0);
    endtask

    initial begin
        nReset   = 1'b0;
        cmdValid = 1'b1;
        cmdAddr  = 32'h40;
        cmdWData = 32'hFFFF_FFFF;
        cmdWrite = 1'b1;
        cmdSize  = 3'd2;
        readyOut = 1'b1;
        resp     = RESP_OKAY;
        rData    = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        cmdValid = 1'b0;
        nReset   = 1'b1;
        drive_slave();

        // single zero-wait write
        stim_q.push_back(mk(32'h100, 32'hDEAD_BEEF, 1'b1, 3'd2));
        drain("single_write", 50);
        check("single_write_rsps", rsp_log.size(), 1);
        if (rsp_log.size() >= 1) begin
            check("single_write_lat", rsp_log[0].lat, 3);
            check("single_write_err", rsp_log[0].err, 1'b0);
        end

        // three back-to-back reads
        rsp_log.delete();
        mem[32'h0] = 32'h11; mem[32'h4] = 32'h22; mem[32'h8] = 32'h33;
        for (int i = 0; i < 3; i++) stim_q.push_back(mk(32'(4 * i), '0, 1'b0, 3'd2));
        drain("b2b_reads", 50);
        check("b2b_rsps", rsp_log.size(), 3);
        if (rsp_log.size() >= 3) begin
            check("b2b_data0", rsp_log[0].data, 32'h11);
            check("b2b_data1", rsp_log[1].data, 32'h22);
            check("b2b_data2", rsp_log[2].data, 32'h33);
            check("b2b_consec1", rsp_log[1].cycle, rsp_log[0].cycle + 1);
            check("b2b_consec2", rsp_log[2].cycle, rsp_log[1].cycle + 1);
        end

        // read with three wait states
        rsp_log.delete();
        plan_q.push_back(mkp(3, 0));
        stim_q.push_back(mk(32'h4, '0, 1'b0, 3'd2));
        drain("wait_read", 50);
        check("wait_read_rsps", rsp_log.size(), 1);
        if (rsp_log.size() >= 1) begin
            check("wait_read_lat", rsp_log[0].lat, 3 + 3);
            check("wait_read_data", rsp_log[0].data, 32'h22);
        end

        // erroring write followed immediately by a read
        rsp_log.delete();
        plan_q.push_back(mkp(0, 1));
        plan_q.push_back(mkp(0, 0));
        stim_q.push_back(mk(32'h8, 32'hCAFE_0000, 1'b1, 3'd2));
        stim_q.push_back(mk(32'h8, '0, 1'b0, 3'd1));
        drain("err_write", 50);
        check("err_rsps", rsp_log.size(), 2);
        if (rsp_log.size() >= 2) begin
            check("err_write_err", rsp_log[0].err, 1'b1);
            check("err_read_err", rsp_log[1].err, 1'b0);
            check("err_read_data", rsp_log[1].data, 32'h33);
        end

        // reset while a transfer sits in the data phase
        begin
            int n = 0;
            rsp_log.delete();
            plan_q.push_back(mkp(2, 0));
            stim_q.push_back(mk(32'h200, 32'h5555_AAAA, 1'b1, 3'd2));
            while (!dp_active && n < 20) begin step(); n++; end
            check("mid_reset_reach_d", dp_active, 1'b1);
            #2;
            nReset = 1'b0;
            #1;
            check_reset_outputs("mid_reset");
            stim_q.delete(); acc_q.delete(); acc_cyc_q.delete(); plan_q.delete();
            dp_active   = 0;
            rsp_pending = 0;
            prev_wait   = 0;
            cmdValid    = 1'b0;
            drive_slave();
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("reset_no_rsp", rspValid, 1'b0);
            end
            @(posedge clk);
            #1;
            nReset = 1'b1;
            stim_q.push_back(mk(32'h0, '0, 1'b0, 3'd0));
            drain("post_reset", 50);
            check("post_reset_rsps", rsp_log.size(), 1);
            if (rsp_log.size() >= 1) begin
                check("post_reset_lat", rsp_log[0].lat, 3);
                check("post_reset_data", rsp_log[0].data, 32'h11);
            end
        end

        // randomized traffic against the model
        cmd_rate   = 70;
        rand_plans = 1;
        for (int i = 0; i < 300; i++) begin
            stim_q.push_back(mk({25'd0, 5'($urandom_range(0, 31)), 2'b00}, $urandom,
                                1'($urandom_range(0, 1)), 3'($urandom_range(0, 2))));
        end
        drain("random", 5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule : tb_ahb_cmd_manager
